router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
Control FSM of a 1-input, 3-output packet router. It decodes the 2-bit destination address from the packet header and sequences header, payload and parity loading into the addressed output FIFO. It handles FIFO-full stalls and per-port soft resets. Its Moore outputs drive the router's register block (header/data/parity latching) and the FIFO write-enable synchroniser.

Parameters:
None (state encoding fixed, 3 bits).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
soft_rst_0  input  1  soft reset from output port 0 (read timeout)
soft_rst_1  input  1  soft reset from output port 1
soft_rst_2  input  1  soft reset from output port 2
pkt_valid  input  1  high while header/payload bytes are presented; falls with parity byte
fifo_full  input  1  addressed FIFO full
fifo_empty_0  input  1  FIFO 0 empty
fifo_empty_1  input  1  FIFO 1 empty
fifo_empty_2  input  1  FIFO 2 empty
parity_done  input  1  register block has latched parity byte
low_pkt_valid  input  1  register block saw pkt_valid fall while stalled
d_in  input  2  destination address (header bits [1:0])
wr_en_reg  output  1  FIFO write enable request
detect_add  output  1  in DECODE_ADDRESS
ld_state  output  1  in LOAD_DATA
laf_state  output  1  in LOAD_AFTER_FULL
lfd_state  output  1  in LOAD_FIRST_DATA
full_state  output  1  in FIFO_FULL_STATE
rst_int_reg  output  1  in CHECK_PARITY_ERROR
busy  output  1  router cannot accept a new byte

Behaviour:
- Single clock domain, with the synchronous active-high reset on rst. There are 8 states. All outputs are pure decodes of the state (Moore), so there are no output registers.
- Reset (rst=1 at a clock edge) forces the state to DECODE_ADDRESS. After reset: detect_add=1 and all other outputs are 0.
- addr_reg (2 bits) latches d_in on the clock edge when state=DECODE_ADDRESS and pkt_valid=1. It resets to 0.
- Soft reset: if soft_rst_k=1 and addr_reg==k, the next state is DECODE_ADDRESS. This has priority over all transitions except rst.

Transitions (evaluated when no reset applies):
- DECODE_ADDRESS:
  - pkt_valid and d_in=k (k in 0..2) and fifo_empty_k → LOAD_FIRST_DATA.
  - pkt_valid and d_in=k and !fifo_empty_k → WAIT_TILL_EMPTY.
  - d_in=3, or !pkt_valid → stay.
- LOAD_FIRST_DATA → LOAD_DATA, unconditionally.
- LOAD_DATA:
  - fifo_full → FIFO_FULL_STATE.
  - else !pkt_valid → LOAD_PARITY.
  - else stay.
- FIFO_FULL_STATE: !fifo_full → LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL:
  - parity_done → DECODE_ADDRESS.
  - else low_pkt_valid → LOAD_PARITY.
  - else → LOAD_DATA.
- LOAD_PARITY → CHECK_PARITY_ERROR, unconditionally.
- CHECK_PARITY_ERROR: fifo_full → FIFO_FULL_STATE, else → DECODE_ADDRESS.
- WAIT_TILL_EMPTY: fifo_empty for addr_reg → LOAD_FIRST_DATA, else stay.
- Any unused encoding → DECODE_ADDRESS.

Outputs:
- detect_add=DA; lfd_state=LFD; ld_state=LD; laf_state=LAF; full_state=FFS; rst_int_reg=CPE.
- wr_en_reg = LD | LP | LAF.
- busy = LFD | LP | FFS | LAF | WTE | CPE (low only in DA and LD).

Boundary conditions:
- fifo_full and !pkt_valid both high in LOAD_DATA: fifo_full wins.
- Soft reset for a non-addressed port: ignored.
- rst mid-packet: DA on the next edge; addr_reg is cleared.

Optional Feature:
ROUTER_FSM_DBG_EN: when defined, adds output port state_dbg [2:0] carrying the current state encoding, with a fixed encoding: DA=0, LFD=1, LD=2, FFS=3, LAF=4, LP=5, CPE=6, WTE=7. When undefined, the port is absent and the state encoding is left to the implementation; all other behaviour is identical.

Test Plan:
- rst=1 for 1 cycle, then 0 → detect_add=1, busy=0, wr_en_reg=0, all other outputs 0.
- pkt_valid=1, d_in=0, fifo_empty_0=1 → next cycle lfd_state=1 and busy=1. Then pkt_valid=0, fifo_full=0 → LD (ld_state=1, wr_en_reg=1) → LP (wr_en_reg=1, busy=1) → CPE (rst_int_reg=1) → DA.
- Same start, then fifo_full=1 in LOAD_DATA → full_state=1, wr_en_reg=0. Then fifo_full=0 → laf_state=1. Then parity_done=0, low_pkt_valid=1 → LP. Alternatively parity_done=1 → DA.
- pkt_valid=1, d_in=1, fifo_empty_1=0 → WTE with busy=1, held while fifo_empty_1=0. Then fifo_empty_1=1 → LFD.
- In LD with addr_reg=2, pulse soft_rst_2=1 → DA on the next edge. soft_rst_0=1 in the same situation → no effect.
- d_in=3 with pkt_valid=1 → remains in DA, detect_add=1.

Source files
------------

// File: rtl/router_fsm_if.sv
// router_fsm_if: packet/FIFO status inputs and Moore control outputs
// of the router control FSM.
interface router_fsm_if;
    logic       soft_rst_0;
    logic       soft_rst_1;
    logic       soft_rst_2;
    logic       pkt_valid;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [1:0] d_in;
    logic       wr_en_reg;
    logic       detect_add;
    logic       ld_state;
    logic       laf_state;
    logic       lfd_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       busy;

    modport master (
        output soft_rst_0, soft_rst_1, soft_rst_2,
        output pkt_valid, fifo_full,
        output fifo_empty_0, fifo_empty_1, fifo_empty_2,
        output parity_done, low_pkt_valid, d_in,
        input  wr_en_reg, detect_add, ld_state, laf_state,
        input  lfd_state, full_state, rst_int_reg, busy
    );

    modport slave (
        input  soft_rst_0, soft_rst_1, soft_rst_2,
        input  pkt_valid, fifo_full,
        input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
        input  parity_done, low_pkt_valid, d_in,
        output wr_en_reg, detect_add, ld_state, laf_state,
        output lfd_state, full_state, rst_int_reg, busy
    );
endinterface

// File: rtl/router_fsm.sv
// router_fsm: header decode / payload / parity sequencing for a 1-in 3-out router.
// Optional ROUTER_FSM_DBG_EN adds a state_dbg[2:0] port.
module router_fsm (
    input  logic          clk,
    input  logic          rst,
`ifdef ROUTER_FSM_DBG_EN
    output logic [2:0]    state_dbg,
`endif
    router_fsm_if.slave   bus
);
    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        FFS = 3'd3,
        LAF = 3'd4,
        LP  = 3'd5,
        CPE = 3'd6,
        WTE = 3'd7
    } state_t;

    state_t     state;
    state_t     next;
    logic [1:0] addr_reg;
    logic       din_empty;
    logic       addr_empty;
    logic       soft_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DA;
            addr_reg <= 2'd0;
        end else begin
            state <= next;
            if (state == DA && bus.pkt_valid)
                addr_reg <= bus.d_in;
        end
    end

    always_comb begin
        din_empty = 1'b0;
        case (bus.d_in)
            2'd0:    din_empty = bus.fifo_empty_0;
            2'd1:    din_empty = bus.fifo_empty_1;
            2'd2:    din_empty = bus.fifo_empty_2;
            default: din_empty = 1'b0;
        endcase
    end

    always_comb begin
        addr_empty = 1'b0;
        case (addr_reg)
            2'd0:    addr_empty = bus.fifo_empty_0;
            2'd1:    addr_empty = bus.fifo_empty_1;
            2'd2:    addr_empty = bus.fifo_empty_2;
            default: addr_empty = 1'b0;
        endcase
    end

    // only the port currently being written may abort the packet
    assign soft_hit = (bus.soft_rst_0 && addr_reg == 2'd0)
                   || (bus.soft_rst_1 && addr_reg == 2'd1)
                   || (bus.soft_rst_2 && addr_reg == 2'd2);

    always_comb begin
        next = state;
        case (state)
            DA: begin
                if (bus.pkt_valid && bus.d_in != 2'd3)
                    next = din_empty ? LFD : WTE;
            end
            LFD: next = LD;
            LD: begin
                if (bus.fifo_full)
                    next = FFS;
                else if (!bus.pkt_valid)
                    next = LP;
            end
            FFS: begin
                if (!bus.fifo_full)
                    next = LAF;
            end
            LAF: begin
                if (bus.parity_done)
                    next = DA;
                else if (bus.low_pkt_valid)
                    next = LP;
                else
                    next = LD;
            end
            LP:  next = CPE;
            CPE: next = bus.fifo_full ? FFS : DA;
            WTE: begin
                if (addr_empty)
                    next = LFD;
            end
            default: next = DA;
        endcase
        if (soft_hit)
            next = DA;
    end

    always_comb begin
        bus.detect_add  = (state == DA);
        bus.lfd_state   = (state == LFD);
        bus.ld_state    = (state == LD);
        bus.laf_state   = (state == LAF);
        bus.full_state  = (state == FFS);
        bus.rst_int_reg = (state == CPE);
        bus.wr_en_reg   = (state == LD) || (state == LP)
                       || (state == LAF);
        bus.busy        = !((state == DA) || (state == LD));
    end

`ifdef ROUTER_FSM_DBG_EN
    assign state_dbg = state;
`endif
endmodule

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed vectors with a queued scoreboard
// checking the Moore outputs of router_fsm after every clock edge.
module tb_router_fsm;
    logic clk;
    logic rst;
`ifdef ROUTER_FSM_DBG_EN
    logic [2:0] state_dbg;
`endif

    router_fsm_if bus ();

    router_fsm dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ROUTER_FSM_DBG_EN
        .state_dbg (state_dbg),
`endif
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {wr_en, detect_add, ld, laf, lfd, full, rst_int, busy}
    localparam logic [7:0] E_DA  = 8'b0100_0000;
    localparam logic [7:0] E_LFD = 8'b0000_1001;
    localparam logic [7:0] E_LD  = 8'b1010_0000;
    localparam logic [7:0] E_FFS = 8'b0000_0101;
    localparam logic [7:0] E_LAF = 8'b1001_0001;
    localparam logic [7:0] E_LP  = 8'b1000_0001;
    localparam logic [7:0] E_CPE = 8'b0000_0011;
    localparam logic [7:0] E_WTE = 8'b0000_0001;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    function automatic logic [7:0] outs();
        return {bus.wr_en_reg, bus.detect_add, bus.ld_state,
                bus.laf_state, bus.lfd_state, bus.full_state,
                bus.rst_int_reg, bus.busy};
    endfunction

    // expectation applies to the outputs after the coming rising edge
    task automatic tick(input logic [7:0] e, input string n);
        exp_t x;
        x.exp  = e;
        x.name = n;
        q.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst               = 1'b0;
        bus.soft_rst_0    = 1'b0;
        bus.soft_rst_1    = 1'b0;
        bus.soft_rst_2    = 1'b0;
        bus.pkt_valid     = 1'b0;
        bus.fifo_full     = 1'b0;
        bus.fifo_empty_0  = 1'b1;
        bus.fifo_empty_1  = 1'b1;
        bus.fifo_empty_2  = 1'b1;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        bus.d_in          = 2'd0;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t x;
            logic [7:0] a;
            x = q.pop_front();
            a = outs();
            checks++;
            if (a !== x.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", x.name, a, x.exp);
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        tick(E_DA, "reset");
        rst = 1'b0;
        tick(E_DA, "idle_da");

        // simple packet to port 0
        bus.pkt_valid = 1'b1;
        bus.d_in = 2'd0;
        tick(E_LFD, "p0_lfd");
        bus.pkt_valid = 1'b0;
        tick(E_LD, "p0_ld");
        tick(E_LP, "p0_lp");
        tick(E_CPE, "p0_cpe");
        tick(E_DA, "p0_da");

        // stall path, full wins over pkt_valid falling
        bus.pkt_valid = 1'b1;
        tick(E_LFD, "st_lfd");
        tick(E_LD, "st_ld");
        tick(E_LD, "st_ld_hold");
        bus.pkt_valid = 1'b0;
        bus.fifo_full = 1'b1;
        tick(E_FFS, "st_full_wins");
        tick(E_FFS, "st_ffs_hold");
        bus.fifo_full = 1'b0;
        tick(E_LAF, "st_laf");
        bus.low_pkt_valid = 1'b1;
        tick(E_LP, "st_laf_lp");
        bus.low_pkt_valid = 1'b0;
        bus.fifo_full = 1'b1;
        tick(E_CPE, "st_cpe");
        tick(E_FFS, "st_cpe_ffs");
        bus.fifo_full = 1'b0;
        tick(E_LAF, "st_laf2");
        tick(E_LD, "st_laf_ld");
        bus.fifo_full = 1'b1;
        tick(E_FFS, "st_ffs3");
        bus.fifo_full = 1'b0;
        tick(E_LAF, "st_laf3");
        bus.parity_done = 1'b1;
        tick(E_DA, "st_laf_da");
        bus.parity_done = 1'b0;

        // wait for port 1 to drain, then soft resets
        bus.pkt_valid = 1'b1;
        bus.d_in = 2'd1;
        bus.fifo_empty_1 = 1'b0;
        tick(E_WTE, "w1_wte");
        tick(E_WTE, "w1_wte_hold");
        bus.fifo_empty_1 = 1'b1;
        tick(E_LFD, "w1_lfd");
        tick(E_LD, "w1_ld");
        bus.soft_rst_0 = 1'b1;
        tick(E_LD, "w1_sr0_ignored");
        bus.soft_rst_0 = 1'b0;
        bus.soft_rst_1 = 1'b1;
        bus.pkt_valid = 1'b0;
        tick(E_DA, "w1_sr1");
        bus.soft_rst_1 = 1'b0;
        tick(E_DA, "w1_da");

        // soft reset aborts WAIT_TILL_EMPTY
        bus.pkt_valid = 1'b1;
        bus.fifo_empty_1 = 1'b0;
        tick(E_WTE, "w2_wte");
        bus.pkt_valid = 1'b0;
        bus.soft_rst_1 = 1'b1;
        tick(E_DA, "w2_sr1");
        bus.soft_rst_1 = 1'b0;
        bus.fifo_empty_1 = 1'b1;

        // port 2 packet with soft resets
        bus.pkt_valid = 1'b1;
        bus.d_in = 2'd2;
        tick(E_LFD, "p2_lfd");
        tick(E_LD, "p2_ld");
        bus.soft_rst_0 = 1'b1;
        tick(E_LD, "p2_sr0_ignored");
        bus.soft_rst_0 = 1'b0;
        bus.soft_rst_2 = 1'b1;
        bus.pkt_valid = 1'b0;
        tick(E_DA, "p2_sr2");
        bus.soft_rst_2 = 1'b0;

        // address 3 is never routed
        bus.pkt_valid = 1'b1;
        bus.d_in = 2'd3;
        tick(E_DA, "a3_stay");
        tick(E_DA, "a3_stay2");

        // reset mid-packet
        bus.d_in = 2'd0;
        tick(E_LFD, "r_lfd");
        tick(E_LD, "r_ld");
        rst = 1'b1;
        tick(E_DA, "r_mid_rst");
        rst = 1'b0;
        bus.pkt_valid = 1'b0;
        tick(E_DA, "r_da");

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
